// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the v6502 instruction prefetch queue.
// Holds the fetch FSM state encoding, the 6502 reset-vector addresses and
// the default queue geometry used by the top level and its storage.
package inst_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_VEC_LO = 2'd0,
    ST_VEC_HI = 2'd1,
    ST_RUN    = 2'd2
  } pq_state_e;

  localparam logic [15:0] RESET_VEC_LO  = 16'hFFFC;
  localparam logic [15:0] RESET_VEC_HI  = 16'hFFFD;
  localparam int          DEFAULT_DEPTH = 16;
  localparam int          DEFAULT_PTR_W = 4;
  localparam int          DEFAULT_AW    = 16;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, the memory port and the decoder.
// Memory side : mem_req/mem_addr (request), mem_ack/mem_rdata (completion).
// Redirect    : flush/flush_pc.
// Decoder side: dec_byte0..2, dec_avail, inst_pc (queue head view),
//               dec_consume/dec_len (retire an instruction).
// Modport master is the queue itself; slave is its environment.
interface inst_prefetch_queue_if #(
  parameter int AW = 16
) ();
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [7:0]    dec_byte0;
  logic [7:0]    dec_byte1;
  logic [7:0]    dec_byte2;
  logic [1:0]    dec_avail;
  logic          dec_consume;
  logic [1:0]    dec_len;
  logic [AW-1:0] inst_pc;

  modport master (
    output mem_req, mem_addr, dec_byte0, dec_byte1, dec_byte2, dec_avail, inst_pc,
    input  mem_ack, mem_rdata, flush, flush_pc, dec_consume, dec_len
  );

  modport slave (
    input  mem_req, mem_addr, dec_byte0, dec_byte1, dec_byte2, dec_avail, inst_pc,
    output mem_ack, mem_rdata, flush, flush_pc, dec_consume, dec_len
  );
endinterface

// File: rtl/inst_prefetch_queue_storage.sv
// DEPTH x 8 register file backing the prefetch queue.
// Ports: clk, rst_n (async active-low, clears all entries), we/waddr/wdata
// (single write port), raddr (queue head) and rdata0..2 (head, head+1,
// head+2, read combinationally with the index wrapping modulo DEPTH).
module inst_prefetch_queue_storage #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [7:0]       rdata0,
  output logic [7:0]       rdata1,
  output logic [7:0]       rdata2
);
  logic [7:0] mem_r [DEPTH];

  // Entry array: cleared on reset, one byte written per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // PTR_W-bit index arithmetic supplies the wrap from the last entry to 0.
  assign rdata0 = mem_r[raddr];
  assign rdata1 = mem_r[raddr + PTR_W'(1)];
  assign rdata2 = mem_r[raddr + PTR_W'(2)];
endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue for the v6502 core.
// After reset it reads the reset vector ($FFFC/$FFFD), then streams
// sequential bytes into a circular buffer and shows the next three bytes
// to the decoder, which retires dec_len bytes per instruction. A flush
// empties the queue and restarts fetching at flush_pc.
// Ports: clk, rst_n (async active-low), bus (inst_prefetch_queue_if.master).
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = DEFAULT_PTR_W,
  parameter int AW    = DEFAULT_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inst_prefetch_queue_if.master  bus
);
  pq_state_e        state_r, state_n;
  logic [7:0]       vec_lo_r, vec_lo_n;
  logic [PTR_W-1:0] head_r, head_n, tail_r, tail_n;
  logic [PTR_W:0]   count_r, count_n, pop_amt;
  logic [AW-1:0]    fetch_pc_r, fetch_pc_n, inst_pc_r, inst_pc_n;
  logic             in_run, not_full, pop_ok, push, pop;
  logic [7:0]       rd0, rd1, rd2;

  assign in_run   = (state_r == ST_RUN);
  assign not_full = (count_r < (PTR_W+1)'(DEPTH));
  // A retire must name 1..count bytes; anything else is dropped silently.
  assign pop_ok   = bus.dec_consume & (bus.dec_len != 2'd0) &
                    ((PTR_W+1)'(bus.dec_len) <= count_r);
  // Flush outranks both queue operations in the same cycle.
  assign push     = in_run & ~bus.flush & bus.mem_ack & not_full;
  assign pop      = in_run & ~bus.flush & pop_ok;
  assign pop_amt  = pop ? (PTR_W+1)'(bus.dec_len) : (PTR_W+1)'(0);

  inst_prefetch_queue_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (push),
    .waddr  (tail_r),
    .wdata  (bus.mem_rdata),
    .raddr  (head_r),
    .rdata0 (rd0),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Memory request: vector reads are unconditional, RUN fetches while not full.
  always_comb begin
    bus.mem_req  = 1'b1;
    bus.mem_addr = AW'(RESET_VEC_LO);
    case (state_r)
      ST_VEC_LO: begin
        bus.mem_addr = AW'(RESET_VEC_LO);
      end
      ST_VEC_HI: begin
        bus.mem_addr = AW'(RESET_VEC_HI);
      end
      ST_RUN: begin
        bus.mem_req  = not_full & ~bus.flush;
        bus.mem_addr = fetch_pc_r;
      end
      default: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = AW'(RESET_VEC_LO);
      end
    endcase
  end

  // Decoder view: nothing is offered until the vector has been loaded.
  always_comb begin
    bus.dec_avail = 2'd0;
    bus.dec_byte0 = 8'd0;
    bus.dec_byte1 = 8'd0;
    bus.dec_byte2 = 8'd0;
    if (in_run) begin
      if (count_r >= (PTR_W+1)'(3)) begin
        bus.dec_avail = 2'd3;
      end else begin
        bus.dec_avail = count_r[1:0];
      end
      bus.dec_byte0 = rd0;
      bus.dec_byte1 = rd1;
      bus.dec_byte2 = rd2;
    end else begin
      bus.dec_avail = 2'd0;
    end
  end

  assign bus.inst_pc = inst_pc_r;

  // Next-state: vector fetch sequencing, then queue pointer/PC bookkeeping.
  always_comb begin
    state_n    = state_r;
    vec_lo_n   = vec_lo_r;
    head_n     = head_r;
    tail_n     = tail_r;
    count_n    = count_r;
    fetch_pc_n = fetch_pc_r;
    inst_pc_n  = inst_pc_r;
    case (state_r)
      ST_VEC_LO: begin
        if (bus.mem_ack) begin
          vec_lo_n = bus.mem_rdata;
          state_n  = ST_VEC_HI;
        end else begin
          state_n  = ST_VEC_LO;
        end
      end
      ST_VEC_HI: begin
        if (bus.mem_ack) begin
          fetch_pc_n = AW'({bus.mem_rdata, vec_lo_r});
          inst_pc_n  = AW'({bus.mem_rdata, vec_lo_r});
          state_n    = ST_RUN;
        end else begin
          state_n    = ST_VEC_HI;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          head_n     = '0;
          tail_n     = '0;
          count_n    = '0;
          fetch_pc_n = bus.flush_pc;
          inst_pc_n  = bus.flush_pc;
        end else begin
          if (push) begin
            tail_n     = tail_r + PTR_W'(1);
            fetch_pc_n = fetch_pc_r + AW'(1);
          end else begin
            tail_n     = tail_r;
          end
          if (pop) begin
            head_n    = head_r + PTR_W'(bus.dec_len);
            inst_pc_n = inst_pc_r + AW'(bus.dec_len);
          end else begin
            head_n    = head_r;
          end
          count_n = count_r + (PTR_W+1)'(push) - pop_amt;
        end
      end
      default: begin
        state_n = ST_VEC_LO;
      end
    endcase
  end

  // State register for the FSM and all queue bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_VEC_LO;
      vec_lo_r   <= 8'd0;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      fetch_pc_r <= AW'(RESET_VEC_LO);
      inst_pc_r  <= '0;
    end else begin
      state_r    <= state_n;
      vec_lo_r   <= vec_lo_n;
      head_r     <= head_n;
      tail_r     <= tail_n;
      count_r    <= count_n;
      fetch_pc_r <= fetch_pc_n;
      inst_pc_r  <= inst_pc_n;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: a queue-based reference model
// checked every cycle, plus directed scenarios with hand-computed bytes.
module tb_inst_prefetch_queue;
  logic clk = 1'b0;
  logic rst_n;

  inst_prefetch_queue_if #(.AW(16)) bus ();

  inst_prefetch_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory image: reset vector points at $8000, other bytes are address-derived.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h00;
    else if (a == 16'hFFFD) return 8'h80;
    else return (a[7:0] + 8'h5A) ^ a[15:8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state;   // 0 = reading vector lo, 1 = vector hi, 2 = running
  logic [7:0]  m_lo;
  logic [15:0] m_fpc;
  logic [15:0] m_ipc;
  logic [7:0]  q[$];
  int          m_n;
  bit          m_pop, m_push;

  initial begin
    m_state = 0; m_lo = 8'd0; m_fpc = 16'hFFFC; m_ipc = 16'd0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0; m_lo = 8'd0; m_fpc = 16'hFFFC; m_ipc = 16'd0;
        q.delete();
      end else if (m_state == 0) begin
        if (bus.mem_ack) begin m_lo = mem_byte(16'hFFFC); m_state = 1; end
      end else if (m_state == 1) begin
        if (bus.mem_ack) begin
          m_ipc = {mem_byte(16'hFFFD), m_lo};
          m_fpc = m_ipc;
          m_state = 2;
        end
      end else if (bus.flush) begin
        q.delete();
        m_fpc = bus.flush_pc;
        m_ipc = bus.flush_pc;
      end else begin
        m_n    = q.size();
        m_pop  = bus.dec_consume && (bus.dec_len != 2'd0) && (int'(bus.dec_len) <= m_n);
        m_push = bus.mem_ack && (m_n < 16);
        if (m_pop) begin
          for (int i = 0; i < int'(bus.dec_len); i++) void'(q.pop_front());
          m_ipc = m_ipc + 16'(bus.dec_len);
        end
        if (m_push) begin
          q.push_back(mem_byte(m_fpc));
          m_fpc = m_fpc + 16'd1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        c_req;
  logic [15:0] c_addr;
  int          c_av;

  always @(negedge clk) begin
    c_req  = (m_state != 2) ? 1'b1 : ((q.size() < 16) && !bus.flush);
    c_addr = (m_state == 0) ? 16'hFFFC : (m_state == 1) ? 16'hFFFD : m_fpc;
    c_av   = (m_state == 2) ? ((q.size() < 3) ? q.size() : 3) : 0;
    check("mem_req", 32'(bus.mem_req), 32'(c_req));
    check("mem_addr", 32'(bus.mem_addr), 32'(c_addr));
    check("dec_avail", 32'(bus.dec_avail), 32'(c_av));
    check("inst_pc", 32'(bus.inst_pc), 32'(m_ipc));
    if (c_av > 0) check("dec_byte0", 32'(bus.dec_byte0), 32'(q[0]));
    if (c_av > 1) check("dec_byte1", 32'(bus.dec_byte1), 32'(q[1]));
    if (c_av > 2) check("dec_byte2", 32'(bus.dec_byte2), 32'(q[2]));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit ack, input bit cons, input logic [1:0] len,
                     input bit fl, input logic [15:0] fpc, input bit raw_ack);
    @(posedge clk);
    #1;
    bus.dec_consume = cons;
    bus.dec_len     = len;
    bus.flush       = fl;
    bus.flush_pc    = fpc;
    #1;
    bus.mem_ack   = ack & (bus.mem_req | raw_ack);
    bus.mem_rdata = mem_byte(bus.mem_addr);
  endtask

  task automatic step(input bit ack, input bit cons, input logic [1:0] len);
    cyc(ack, cons, len, 1'b0, 16'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'd0; bus.flush = 1'b0; bus.flush_pc = 16'd0;
    bus.dec_consume = 1'b0; bus.dec_len = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", 32'(bus.mem_req), 32'd1);
    check("rst_addr", 32'(bus.mem_addr), 32'hFFFC);
    check("rst_avail", 32'(bus.dec_avail), 32'd0);
    check("rst_byte0", 32'(bus.dec_byte0), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: vector fetch, then sequential fetch from $8000
    step(1'b1, 1'b0, 2'd0); check("t1_lo_addr", 32'(bus.mem_addr), 32'hFFFC);
    step(1'b1, 1'b0, 2'd0); check("t1_hi_addr", 32'(bus.mem_addr), 32'hFFFD);
    step(1'b0, 1'b0, 2'd0);
    check("t1_run_addr", 32'(bus.mem_addr), 32'h8000);
    check("t1_inst_pc", 32'(bus.inst_pc), 32'h8000);

    // 2: fill to DEPTH with zero-wait acks
    repeat (16) step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    check("t2_full_req", 32'(bus.mem_req), 32'd0);
    check("t2_avail", 32'(bus.dec_avail), 32'd3);
    check("t2_b0", 32'(bus.dec_byte0), 32'hDA);
    check("t2_b1", 32'(bus.dec_byte1), 32'hDB);
    check("t2_b2", 32'(bus.dec_byte2), 32'hDC);

    // 3: bring count to 5, then push and pop 2 in one cycle
    repeat (3) step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b0, 2'd0);
    check("t3_pc", 32'(bus.inst_pc), 32'h800B);
    check("t3_b2", 32'(bus.dec_byte2), 32'hE7);
    step(1'b1, 1'b1, 2'd2);
    step(1'b0, 1'b0, 2'd0);
    check("t3_pc2", 32'(bus.inst_pc), 32'h800D);
    check("t3_b0", 32'(bus.dec_byte0), 32'hE7);

    // 4: head at entry 14, read wraps to entry 0
    step(1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b0, 2'd0);
    check("t4_pc", 32'(bus.inst_pc), 32'h800E);
    check("t4_b0", 32'(bus.dec_byte0), 32'hE8);
    check("t4_b1", 32'(bus.dec_byte1), 32'hE9);
    check("t4_b2", 32'(bus.dec_byte2), 32'hEA);

    // 5: flush with simultaneous ack and consume
    cyc(1'b1, 1'b1, 2'd1, 1'b1, 16'h1234, 1'b1);
    check("t5_flush_req", 32'(bus.mem_req), 32'd0);
    step(1'b0, 1'b0, 2'd0);
    check("t5_avail", 32'(bus.dec_avail), 32'd0);
    check("t5_addr", 32'(bus.mem_addr), 32'h1234);
    check("t5_pc", 32'(bus.inst_pc), 32'h1234);
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    check("t5_b0", 32'(bus.dec_byte0), 32'h9C);

    // 4b: fetch_pc and inst_pc wrap past $FFFF
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    check("t4w_addr", 32'(bus.mem_addr), 32'h0000);
    check("t4w_b0", 32'(bus.dec_byte0), 32'hA6);
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    check("t4w_b1", 32'(bus.dec_byte1), 32'h5A);
    check("t4w_b2", 32'(bus.dec_byte2), 32'h5B);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b0, 2'd0);
    check("t4w_pc", 32'(bus.inst_pc), 32'h0002);
    check("t4w_avail", 32'(bus.dec_avail), 32'd0);

    // 6: illegal consume lengths are ignored
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 16'h2000, 1'b0);
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    check("t6_avail", 32'(bus.dec_avail), 32'd2);
    check("t6_pc", 32'(bus.inst_pc), 32'h2000);

    // 6b: asynchronous reset mid-run, flush ignored during vector fetch
    #1; rst_n = 1'b0;
    #1;
    check("t6_rst_addr", 32'(bus.mem_addr), 32'hFFFC);
    check("t6_rst_avail", 32'(bus.dec_avail), 32'd0);
    check("t6_rst_pc", 32'(bus.inst_pc), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 16'h4444, 1'b0);
    step(1'b0, 1'b0, 2'd0);
    check("t6_vec_pc", 32'(bus.inst_pc), 32'h8000);
    check("t6_vec_addr", 32'(bus.mem_addr), 32'h8000);

    // Pseudo-random traffic checked by the model alone
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0), 16'($urandom), 1'b0);
    end
    step(1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
